// File: rtl/spin_readout_streamer.sv
// Spin snapshot ring buffer that streams stored entries out as bytes.
// Entries are sent LSB byte first over a valid/ready byte port.
module spin_readout_streamer #(
   parameter int N_SPIN = 50,
   parameter int DEPTH  = 200,
   parameter int WRAP   = 0,
   localparam int NB    = (N_SPIN + 7) / 8,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              capture_en,
   input  logic [N_SPIN-1:0] spin_read_out,
   input  logic              start_dump,
   input  logic              dump_mode,
   input  logic              out_ready,
   output logic [7:0]        out_GPIO,
   output logic              out_GPIO_valid,
   output logic              busy,
   output logic              dump_done,
   output logic              buffer_full,
   output logic              buffer_empty,
   output logic [CW-1:0]     entry_count,
   output logic              overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int EW = NB * 8;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

   state_t            state;
   logic [N_SPIN-1:0] mem [DEPTH];
   logic [PW-1:0]     wp;
   logic [PW-1:0]     rp;
   logic [CW-1:0]     count;
   logic              mode;
   logic [BW-1:0]     bidx;
   logic [EW-1:0]     sr;

   logic              full;
   logic              wr_en;
   logic              xfer;
   logic              last;
   logic              pop;
   logic [CW-1:0]     cnt_nxt;
   logic [PW-1:0]     nsel;
   logic [EW-1:0]     ext;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign entry_count = count;

   always_comb begin
      full    = (count == CW'(DEPTH));
      wr_en   = (state == IDLE) && capture_en && (!full || (WRAP != 0));
      xfer    = (state == SEND) && out_GPIO_valid && out_ready;
      last    = (bidx == BW'(NB - 1));
      pop     = xfer && last && !mode;
      cnt_nxt = count;
      if (wr_en && !full)
         cnt_nxt = count + 1'b1;
      else if (pop)
         cnt_nxt = count - 1'b1;
      nsel    = (wp == '0) ? PW'(DEPTH - 1) : wp - 1'b1;
      ext     = EW'(mem[mode ? nsel : rp]);
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (wr_en)
         mem[wp] <= spin_read_out;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= IDLE;
         wp             <= '0;
         rp             <= '0;
         count          <= '0;
         mode           <= 1'b0;
         bidx           <= '0;
         sr             <= '0;
         out_GPIO       <= '0;
         out_GPIO_valid <= 1'b0;
         busy           <= 1'b0;
         dump_done      <= 1'b0;
         overflow       <= 1'b0;
         buffer_empty   <= 1'b1;
         buffer_full    <= 1'b0;
      end else begin
         count        <= cnt_nxt;
         buffer_full  <= (cnt_nxt == CW'(DEPTH));
         buffer_empty <= (cnt_nxt == '0);
         dump_done    <= 1'b0;
         if (wr_en) begin
            wp <= inc(wp);
            if (full)
               rp <= inc(rp);
         end
         unique case (state)
            IDLE: begin
               if (start_dump) begin
                  overflow <= 1'b0;
                  mode     <= dump_mode;
                  if (count != '0) begin
                     state <= LOAD;
                     busy  <= 1'b1;
                  end else begin
                     dump_done <= 1'b1;
                  end
               end
            end
            LOAD: begin
               sr             <= ext >> 8;
               out_GPIO       <= ext[7:0];
               out_GPIO_valid <= 1'b1;
               bidx           <= '0;
               state          <= SEND;
            end
            SEND: begin
               if (xfer) begin
                  if (last) begin
                     out_GPIO_valid <= 1'b0;
                     if (!mode && (cnt_nxt != '0)) begin
                        state <= LOAD;
                     end else begin
                        state     <= FIN;
                        dump_done <= 1'b1;
                     end
                     if (!mode)
                        rp <= inc(rp);
                  end else begin
                     out_GPIO <= sr[7:0];
                     sr       <= sr >> 8;
                     bidx     <= bidx + 1'b1;
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Dropped, overwritten or mid-dump captures all count as lost data.
         if (capture_en && ((state != IDLE) || full))
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spin_readout_streamer.sv
// Bench for spin_readout_streamer: WRAP=0 and WRAP=1 instances side by side.
// Byte stream is checked against a scoreboard queue per instance.
module tb_spin_readout_streamer;

   localparam int N  = 50;
   localparam int D  = 4;
   localparam int CW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          i_rst;
   logic          capture_en;
   logic          start_dump;
   logic          dump_mode;
   logic          out_ready;
   logic [N-1:0]  spin;
   logic [7:0]    g0, g1;
   logic          v0, v1, b0, b1, dd0, dd1;
   logic          f0, f1, e0, e1, ov0, ov1;
   logic [CW-1:0] c0, c1;

   spin_readout_streamer #(.N_SPIN(N), .DEPTH(D), .WRAP(0)) u0 (
      .i_clk(clk), .i_rst(i_rst), .capture_en(capture_en),
      .spin_read_out(spin), .start_dump(start_dump),
      .dump_mode(dump_mode), .out_ready(out_ready),
      .out_GPIO(g0), .out_GPIO_valid(v0), .busy(b0),
      .dump_done(dd0), .buffer_full(f0), .buffer_empty(e0),
      .entry_count(c0), .overflow(ov0)
   );

   spin_readout_streamer #(.N_SPIN(N), .DEPTH(D), .WRAP(1)) u1 (
      .i_clk(clk), .i_rst(i_rst), .capture_en(capture_en),
      .spin_read_out(spin), .start_dump(start_dump),
      .dump_mode(dump_mode), .out_ready(out_ready),
      .out_GPIO(g1), .out_GPIO_valid(v1), .busy(b1),
      .dump_done(dd1), .buffer_full(f1), .buffer_empty(e1),
      .entry_count(c1), .overflow(ov1)
   );

   int ntest = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   logic [7:0]   q0[$];
   logic [7:0]   q1[$];
   logic [N-1:0] m0[$];
   logic [N-1:0] m1[$];
   logic         st0 = 1'b0;
   logic         st1 = 1'b0;
   logic [7:0]   pg0, pg1;

   always @(negedge clk) begin
      if (v0) begin
         if (st0) chk("hold0", g0, pg0);
         if (out_ready) begin
            if (q0.size() == 0) begin
               ntest++;
               nfail++;
               $display("FAIL extra0: unexpected byte %0h", g0);
            end else begin
               chk("byte0", g0, q0.pop_front());
            end
         end
      end
      st0 = v0 && !out_ready;
      pg0 = g0;
   end

   always @(negedge clk) begin
      if (v1) begin
         if (st1) chk("hold1", g1, pg1);
         if (out_ready) begin
            if (q1.size() == 0) begin
               ntest++;
               nfail++;
               $display("FAIL extra1: unexpected byte %0h", g1);
            end else begin
               chk("byte1", g1, q1.pop_front());
            end
         end
      end
      st1 = v1 && !out_ready;
      pg1 = g1;
   end

   task automatic cap(input logic [N-1:0] d);
      capture_en = 1'b1;
      spin       = d;
      @(posedge clk); #1;
      capture_en = 1'b0;
      if (m0.size() < D) m0.push_back(d);
      if (m1.size() == D) void'(m1.pop_front());
      m1.push_back(d);
   endtask

   task automatic push_bytes(input int which, input logic [N-1:0] d);
      logic [55:0] t;
      t = 56'(d);
      for (int k = 0; k < 7; k++) begin
         if (which == 0) q0.push_back(t[8*k +: 8]);
         else            q1.push_back(t[8*k +: 8]);
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      m0.delete(); m1.delete();
      q0.delete(); q1.delete();
   endtask

   task automatic run_dump(input logic mode, input bit pat,
                           input int cap_at, input int rst_at,
                           output int first, output int d0,
                           output int d1);
      bit [3:0] p = 4'b1001;
      int dn = 0;
      first = -1; d0 = -1; d1 = -1;
      for (int c = 0; c < 300; c++) begin
         start_dump = (c == 0);
         dump_mode  = mode;
         capture_en = (c == cap_at);
         i_rst      = (c == rst_at);
         out_ready  = pat ? p[c % 4] : 1'b1;
         @(negedge clk);
         if (v0 && first < 0) first = c;
         if (dd0) begin if (d0 < 0) d0 = c; else dn++; end
         if (dd1) begin if (d1 < 0) d1 = c; else dn++; end
         if (rst_at >= 0 && c == rst_at + 1) begin
            chk("rst_valid0", v0, 0);
            chk("rst_busy0", b0, 0);
            chk("rst_cnt0", c0, 0);
            chk("rst_valid1", v1, 0);
            chk("rst_busy1", b1, 0);
            chk("rst_cnt1", c1, 0);
         end
         @(posedge clk); #1;
         if (rst_at < 0 && d0 >= 0 && d1 >= 0) break;
         if (rst_at >= 0 && c == rst_at + 8) break;
      end
      start_dump = 1'b0;
      capture_en = 1'b0;
      i_rst      = 1'b0;
      out_ready  = 1'b1;
      if (rst_at < 0 && (d0 < 0 || d1 < 0)) begin
         ntest++;
         nfail++;
         $display("FAIL dump_timeout: no dump_done within budget");
      end
      chk("extra_done", dn, 0);
   endtask

   typedef struct {
      logic [N-1:0] data;
      logic [55:0]  bytes;
   } vec_t;

   vec_t tbl[5];
   int   fst, a0, a1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{50'h3_FFFF_0000_1234, 56'h03_FF_FF_00_00_12_34};
      tbl[1] = '{50'h2_AAAA_5555_00FF, 56'h02_AA_AA_55_55_00_FF};
      tbl[2] = '{50'h1_0203_0405_0607, 56'h01_02_03_04_05_06_07};
      tbl[3] = '{50'h0,                56'h00_00_00_00_00_00_00};
      tbl[4] = '{50'h3_FFFF_FFFF_FFFF, 56'h03_FF_FF_FF_FF_FF_FF};

      i_rst = 1'b1; capture_en = 1'b0; start_dump = 1'b0;
      dump_mode = 1'b0; out_ready = 1'b1; spin = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_rst = 1'b0;

      chk("reset_valid", v0, 0);
      chk("reset_busy", b0, 0);
      chk("reset_done", dd0, 0);
      chk("reset_ovf", ov0, 0);
      chk("reset_empty", e0, 1);
      chk("reset_full", f0, 0);
      chk("reset_count", c0, 0);
      chk("reset_gpio", g0, 0);

      for (int i = 0; i < 5; i++) begin
         cap(tbl[i].data);
         chk("tbl_count1", c0, 1);
         for (int k = 0; k < 7; k++) begin
            q0.push_back(tbl[i].bytes[8*k +: 8]);
            q1.push_back(tbl[i].bytes[8*k +: 8]);
         end
         m0.delete(); m1.delete();
         run_dump(1'b0, 1'b0, -1, -1, fst, a0, a1);
         chk("tbl_first", fst, 2);
         chk("tbl_done0", a0, 9);
         chk("tbl_done1", a1, 9);
         chk("tbl_count0", c0, 0);
         chk("tbl_empty", e0, 1);
         chk("tbl_pulse", dd0, 0);
         chk("tbl_idle", b0, 0);
         chk("tbl_drain", q0.size(), 0);
      end

      do_reset();
      for (int i = 0; i < 5; i++)
         cap(N'(64'h1111_1111_1111 * (i + 1)));
      chk("wrap0_count", c0, 4);
      chk("wrap0_full", f0, 1);
      chk("wrap0_ovf", ov0, 1);
      chk("wrap1_count", c1, 4);
      chk("wrap1_full", f1, 1);
      chk("wrap1_ovf", ov1, 1);
      foreach (m0[i]) push_bytes(0, m0[i]);
      foreach (m1[i]) push_bytes(1, m1[i]);
      m0.delete(); m1.delete();
      run_dump(1'b0, 1'b1, -1, -1, fst, a0, a1);
      chk("stall_first", fst, 2);
      chk("stall_drain0", q0.size(), 0);
      chk("stall_drain1", q1.size(), 0);
      chk("stall_ovf_clr0", ov0, 0);
      chk("stall_count0", c0, 0);
      chk("stall_count1", c1, 0);

      do_reset();
      for (int i = 0; i < 3; i++)
         cap(N'(64'h0_5A5A_0000_0100 + 64'(i * 3)));
      push_bytes(0, m0[$]);
      push_bytes(1, m1[$]);
      run_dump(1'b1, 1'b0, -1, -1, fst, a0, a1);
      chk("m1_done", a0, 9);
      chk("m1_count0", c0, 3);
      chk("m1_count1", c1, 3);
      chk("m1_drain", q0.size(), 0);

      do_reset();
      run_dump(1'b0, 1'b0, -1, -1, fst, a0, a1);
      chk("empty_novalid", fst, -1);
      chk("empty_done", a0, 1);
      chk("empty_pulse", dd0, 0);

      do_reset();
      cap(50'h1_2345_6789_ABCD);
      cap(50'h2_0F0F_F0F0_1357);
      foreach (m0[i]) push_bytes(0, m0[i]);
      foreach (m1[i]) push_bytes(1, m1[i]);
      m0.delete(); m1.delete();
      spin = 50'h3_DEAD_BEEF_0000;
      run_dump(1'b0, 1'b0, 4, -1, fst, a0, a1);
      chk("busycap_done", a0, 17);
      chk("busycap_ovf0", ov0, 1);
      chk("busycap_ovf1", ov1, 1);
      chk("busycap_count", c0, 0);
      chk("busycap_drain", q0.size(), 0);

      do_reset();
      cap(50'h0_1111_2222_3333);
      cap(50'h0_4444_5555_6666);
      foreach (m0[i]) push_bytes(0, m0[i]);
      foreach (m1[i]) push_bytes(1, m1[i]);
      run_dump(1'b0, 1'b0, -1, 13, fst, a0, a1);
      chk("abort_nodone0", a0, -1);
      chk("abort_nodone1", a1, -1);
      chk("abort_empty", e0, 1);
      q0.delete(); q1.delete();
      m0.delete(); m1.delete();

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
